// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX-stage connection between the decode/operand side and the
// iterative multiply/divide unit. The master drives the op flags and
// operands. The slave (the unit) returns busy/stall, the HI/LO read result
// and the architectural HI/LO registers.
interface ex_muldiv_if;
  logic        flush;
  logic        mult;
  logic        div;
  logic        mfhi;
  logic        mflo;
  logic        mthi;
  logic        mtlo;
  logic [31:0] busA;
  logic [31:0] busB;
  logic        busy;
  logic        stall;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output flush, mult, div, mfhi, mflo, mthi, mtlo, busA, busB,
    input  busy, stall, result, hi, lo
  );

  modport slave (
    input  flush, mult, div, mfhi, mflo, mthi, mtlo, busA, busB,
    output busy, stall, result, hi, lo
  );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative signed multiply (and optional restoring divide) unit
// with the architectural HI/LO registers, sitting in the EX stage.
// Multiply retires BITS_PER_CYCLE multiplier bits per cycle (1, 2, 4 or 8).
// Optional feature macro: EX_MULDIV_DIVIDE_EN compiles in the divide
// datapath and the div issue path. When it is undefined, div is ignored.
module ex_muldiv #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  ex_muldiv_if.slave  bus
);

  localparam int         N        = 32 / BITS_PER_CYCLE;
  localparam logic [4:0] MUL_LAST = 5'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Magnitude of a two's-complement word (|0x80000000| stays 0x80000000)
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  // Conditional two's-complement negate, 32 bits
  function automatic logic [31:0] neg32_if(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

  // Conditional two's-complement negate, 64 bits
  function automatic logic [63:0] neg64_if(input logic [63:0] v, input logic n);
    return n ? (~v + 64'd1) : v;
  endfunction

  state_t      state_r;
  state_t      state_next_s;
  logic        busy_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic [63:0] acc_r;
  logic [63:0] mcand_r;
  logic [31:0] mplier_r;
  logic [4:0]  cnt_r;
  logic        neg_r;

  logic        mult_req_s;
  logic        div_req_s;
  logic        op_req_s;
  logic        move_any_s;
  logic        stall_s;
  logic        last_s;
  logic        op_div_s;
  logic        issue_s;
  logic        step_s;
  logic        fix_we_s;
  logic        mthi_we_s;
  logic        mtlo_we_s;
  logic [63:0] slice_ext_s;
  logic [63:0] mul_partial_s;
  logic [63:0] fix_prod_s;
  logic [31:0] fix_hi_s;
  logic [31:0] fix_lo_s;

`ifdef EX_MULDIV_DIVIDE_EN
  logic        op_div_r;
  logic        sign_a_r;
  logic        div_zero_r;
  logic [32:0] div_rem_sh_s;
  logic [32:0] div_diff_s;
  logic        div_qbit_s;
  logic [31:0] div_rem_s;

  assign div_req_s = bus.div;
  assign op_div_s  = op_div_r;
`else
  logic        unused_div_s;

  assign unused_div_s = bus.div;
  assign div_req_s    = 1'b0;
  assign op_div_s     = 1'b0;
`endif

  assign mult_req_s = bus.mult;
  assign op_req_s   = mult_req_s | div_req_s;
  assign move_any_s = bus.mfhi | bus.mflo | bus.mthi | bus.mtlo;
  assign stall_s    = busy_r & (op_req_s | move_any_s);
  assign last_s     = op_div_s ? (cnt_r == 5'd31) : (cnt_r == MUL_LAST);

  assign bus.busy   = busy_r;
  assign bus.stall  = stall_s;
  assign bus.hi     = hi_r;
  assign bus.lo     = lo_r;

  // State register and registered busy flag (busy mirrors "next state is not IDLE")
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
    end
  end

  // Next-state logic: issue from IDLE, iterate in RUN, one FIX cycle, flush aborts
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (op_req_s && !bus.flush) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_next_s = IDLE;
        end else if (last_s) begin
          state_next_s = FIX;
        end else begin
          state_next_s = RUN;
        end
      end
      FIX:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: issue/step/writeback strobes and move-to-HI/LO enables
  always_comb begin
    issue_s   = 1'b0;
    step_s    = 1'b0;
    fix_we_s  = 1'b0;
    mthi_we_s = 1'b0;
    mtlo_we_s = 1'b0;
    case (state_r)
      IDLE: begin
        issue_s   = op_req_s & ~bus.flush;
        mthi_we_s = ~bus.flush & ~op_req_s & ~stall_s & bus.mthi;
        mtlo_we_s = ~bus.flush & ~op_req_s & ~stall_s & ~bus.mthi & bus.mtlo;
      end
      RUN:     step_s   = ~bus.flush;
      FIX:     fix_we_s = ~bus.flush;
      default: issue_s  = 1'b0;
    endcase
  end

  // One multiply step: |A| (pre-shifted) times the low multiplier slice
  always_comb begin
    slice_ext_s   = {{(64 - BITS_PER_CYCLE){1'b0}}, mplier_r[BITS_PER_CYCLE-1:0]};
    mul_partial_s = mcand_r * slice_ext_s;
  end

`ifdef EX_MULDIV_DIVIDE_EN
  // One restoring-divide step: shift in the next dividend bit, trial-subtract
  always_comb begin
    div_rem_sh_s = {acc_r[63:32], mcand_r[31]};
    div_diff_s   = div_rem_sh_s - {1'b0, mplier_r};
    div_qbit_s   = ~div_diff_s[32];
    if (div_qbit_s) begin
      div_rem_s = div_diff_s[31:0];
    end else begin
      div_rem_s = div_rem_sh_s[31:0];
    end
  end

  // Divide bookkeeping captured at issue: op kind, dividend sign, zero divisor
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_div_r   <= 1'b0;
      sign_a_r   <= 1'b0;
      div_zero_r <= 1'b0;
    end else if (issue_s) begin
      op_div_r   <= div_req_s & ~mult_req_s;
      sign_a_r   <= bus.busA[31];
      div_zero_r <= (bus.busB == 32'd0);
    end
  end
`endif

  // Operand capture at issue and per-cycle iteration of the active op
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r    <= 64'd0;
      mcand_r  <= 64'd0;
      mplier_r <= 32'd0;
      cnt_r    <= 5'd0;
      neg_r    <= 1'b0;
    end else if (issue_s) begin
      acc_r    <= 64'd0;
      mcand_r  <= {32'd0, mag32(bus.busA)};
      mplier_r <= mag32(bus.busB);
      cnt_r    <= 5'd0;
      neg_r    <= bus.busA[31] ^ bus.busB[31];
    end else if (step_s) begin
      cnt_r <= cnt_r + 5'd1;
`ifdef EX_MULDIV_DIVIDE_EN
      if (op_div_r) begin
        acc_r   <= {div_rem_s, acc_r[30:0], div_qbit_s};
        mcand_r <= mcand_r << 1;
      end else begin
        acc_r    <= acc_r + mul_partial_s;
        mcand_r  <= mcand_r << BITS_PER_CYCLE;
        mplier_r <= mplier_r >> BITS_PER_CYCLE;
      end
`else
      acc_r    <= acc_r + mul_partial_s;
      mcand_r  <= mcand_r << BITS_PER_CYCLE;
      mplier_r <= mplier_r >> BITS_PER_CYCLE;
`endif
    end
  end

  // Sign fix-up of the magnitude result into the HI/LO values to write back
  always_comb begin
    fix_prod_s = neg64_if(acc_r, neg_r);
    fix_hi_s   = fix_prod_s[63:32];
    fix_lo_s   = fix_prod_s[31:0];
`ifdef EX_MULDIV_DIVIDE_EN
    if (op_div_r) begin
      // Remainder follows the dividend sign; with a zero divisor it equals the dividend
      fix_hi_s = neg32_if(acc_r[63:32], sign_a_r);
      if (div_zero_r) begin
        fix_lo_s = 32'hFFFF_FFFF;
      end else begin
        fix_lo_s = neg32_if(acc_r[31:0], neg_r);
      end
    end else begin
      fix_hi_s = fix_prod_s[63:32];
      fix_lo_s = fix_prod_s[31:0];
    end
`endif
  end

  // HI register: written by FIX or by mthi
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_r <= 32'd0;
    end else if (fix_we_s) begin
      hi_r <= fix_hi_s;
    end else if (mthi_we_s) begin
      hi_r <= bus.busA;
    end
  end

  // LO register: written by FIX or by mtlo
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lo_r <= 32'd0;
    end else if (fix_we_s) begin
      lo_r <= fix_lo_s;
    end else if (mtlo_we_s) begin
      lo_r <= bus.busA;
    end
  end

  // HI/LO read path to the EX result mux (no bypass from FIX)
  always_comb begin
    if (bus.mfhi) begin
      bus.result = hi_r;
    end else if (bus.mflo) begin
      bus.result = lo_r;
    end else begin
      bus.result = 32'd0;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: scoreboard bench for ex_muldiv. Each issued op pushes its
// expected HI/LO and busy length. Per-DUT monitors pop and compare when
// busy falls. Two DUTs are instantiated: BITS_PER_CYCLE = 1 and = 4.
module tb_ex_muldiv;

  typedef struct {
    string       nm;
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;
  exp_t q1[$];
  exp_t q4[$];

  ex_muldiv_if if1();
  ex_muldiv_if if4();

  ex_muldiv #(.BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  ex_muldiv #(.BITS_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Issue one op on DUT d (1 or 4) from an aligned point (just after a posedge)
  task automatic issue(input int d, input logic m, input logic dv,
                       input logic [31:0] a, input logic [31:0] b, input string nm,
                       input logic [31:0] ehi, input logic [31:0] elo, input int len);
    exp_t e;
    e.nm = nm; e.hi = ehi; e.lo = elo; e.len = len;
    if (d == 4) begin
      q4.push_back(e);
      if4.mult = m; if4.div = dv; if4.busA = a; if4.busB = b;
    end else begin
      q1.push_back(e);
      if1.mult = m; if1.div = dv; if1.busA = a; if1.busB = b;
    end
    @(posedge clk); #1;
    if1.mult = 1'b0; if1.div = 1'b0;
    if4.mult = 1'b0; if4.div = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((if1.busy !== 1'b0) || (if4.busy !== 1'b0)) && (n < 200));
    chk("wait_idle", 32'(if1.busy | if4.busy), 32'd0);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor for the BITS_PER_CYCLE = 1 unit
  initial begin : mon1
    bit   bprev;
    int   bcnt;
    exp_t e;
    bprev = 1'b0; bcnt = 0;
    forever begin
      @(negedge clk);
      if (if1.busy === 1'b1) bcnt++;
      else begin
        if (bprev) begin
          if (q1.size() == 0) begin
            total_cnt++;
            $display("FAIL dut1_unexpected_done: got busy fall expected none pending");
          end else begin
            e = q1.pop_front();
            chk({e.nm, "_hi"}, if1.hi, e.hi);
            chk({e.nm, "_lo"}, if1.lo, e.lo);
            chk({e.nm, "_busy_len"}, 32'(bcnt), 32'(e.len));
          end
        end
        bcnt = 0;
      end
      bprev = (if1.busy === 1'b1);
    end
  end

  // Scoreboard monitor for the BITS_PER_CYCLE = 4 unit
  initial begin : mon4
    bit   bprev;
    int   bcnt;
    exp_t e;
    bprev = 1'b0; bcnt = 0;
    forever begin
      @(negedge clk);
      if (if4.busy === 1'b1) bcnt++;
      else begin
        if (bprev) begin
          if (q4.size() == 0) begin
            total_cnt++;
            $display("FAIL dut4_unexpected_done: got busy fall expected none pending");
          end else begin
            e = q4.pop_front();
            chk({e.nm, "_hi"}, if4.hi, e.hi);
            chk({e.nm, "_lo"}, if4.lo, e.lo);
            chk({e.nm, "_busy_len"}, 32'(bcnt), 32'(e.len));
          end
        end
        bcnt = 0;
      end
      bprev = (if4.busy === 1'b1);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int scnt;
    logic busy_now;
    pass_cnt = 0; total_cnt = 0;
    rst_n = 1'b0;
    if1.flush = 1'b0; if1.mult = 1'b0; if1.div = 1'b0; if1.mfhi = 1'b0;
    if1.mflo = 1'b0; if1.mthi = 1'b0; if1.mtlo = 1'b0; if1.busA = 32'd0; if1.busB = 32'd0;
    if4.flush = 1'b0; if4.mult = 1'b0; if4.div = 1'b0; if4.mfhi = 1'b0;
    if4.mflo = 1'b0; if4.mthi = 1'b0; if4.mtlo = 1'b0; if4.busA = 32'd0; if4.busB = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(if1.busy), 32'd0);
    chk("rst_stall", 32'(if1.stall), 32'd0);
    chk("rst_result", if1.result, 32'd0);
    chk("rst_hi", if1.hi, 32'd0);
    chk("rst_lo", if1.lo, 32'd0);
    chk("rst_busy4", 32'(if4.busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // BITS_PER_CYCLE = 4: 9-cycle busy
    issue(4, 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, "b4_min_sq", 32'h4000_0000, 32'h0, 9);
    wait_idle();
    issue(4, 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, "b4_7xm3", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 9);
    wait_idle();

    // BITS_PER_CYCLE = 1: 33-cycle busy
    issue(1, 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, "b1_7xm3", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
    wait_idle();
    issue(1, 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, "b1_min_sq", 32'h4000_0000, 32'h0, 33);
    wait_idle();

    // mflo presented 5 cycles after issue: stalls until busy falls
    issue(1, 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, "b1_64k_sq", 32'h1, 32'h0, 33);
    repeat (4) @(posedge clk);
    #1 if1.mflo = 1'b1;
    n = 0; scnt = 0;
    do begin
      @(negedge clk);
      if (if1.stall === 1'b1) scnt++;
      n++;
      busy_now = (if1.busy !== 1'b0);
      if (busy_now) begin
        @(posedge clk); #1;
      end
    end while (busy_now && (n < 100));
    chk("mflo_wait_busy", 32'(if1.busy), 32'd0);
    chk("mflo_stall_cycles", 32'(scnt), 32'd29);
    chk("mflo_unstalled", 32'(if1.stall), 32'd0);
    chk("mflo_result", if1.result, 32'd0);
    chk("mflo_hi", if1.hi, 32'd1);
    @(posedge clk); #1 if1.mflo = 1'b0;

    // mthi then mfhi while idle: no stall, reads new HI
    if1.mthi = 1'b1; if1.busA = 32'h0000_1234;
    @(negedge clk);
    chk("mthi_stall", 32'(if1.stall), 32'd0);
    @(posedge clk); #1;
    if1.mthi = 1'b0; if1.mfhi = 1'b1; if1.busA = 32'd0;
    @(negedge clk);
    chk("mfhi_stall", 32'(if1.stall), 32'd0);
    chk("mfhi_result", if1.result, 32'h0000_1234);
    @(posedge clk); #1 if1.mfhi = 1'b0;

`ifdef EX_MULDIV_DIVIDE_EN
    issue(1, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    wait_idle();
    issue(1, 1'b0, 1'b1, 32'd5, 32'd0, "div_5_0", 32'd5, 32'hFFFF_FFFF, 33);
    wait_idle();
    issue(1, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 32'd0, 32'h8000_0000, 33);
    wait_idle();
`else
    // div ignored: no busy, no stall, HI untouched
    if1.div = 1'b1; if1.busA = 32'd5; if1.busB = 32'd0;
    @(negedge clk);
    chk("nodiv_stall", 32'(if1.stall), 32'd0);
    @(posedge clk); #1 if1.div = 1'b0;
    chk("nodiv_busy_a", 32'(if1.busy), 32'd0);
    @(posedge clk); #1;
    chk("nodiv_busy_b", 32'(if1.busy), 32'd0);
    chk("nodiv_hi", if1.hi, 32'h0000_1234);
`endif

    // Flush on busy cycle 10: HI/LO keep 0xAAAA/0x5555
    if1.mthi = 1'b1; if1.busA = 32'h0000_AAAA;
    @(posedge clk); #1;
    if1.mthi = 1'b0; if1.mtlo = 1'b1; if1.busA = 32'h0000_5555;
    @(posedge clk); #1;
    if1.mtlo = 1'b0;
    issue(1, 1'b1, 1'b0, 32'd3, 32'd5, "flush_mid", 32'h0000_AAAA, 32'h0000_5555, 10);
    repeat (9) @(posedge clk);
    #1 if1.flush = 1'b1;
    @(posedge clk); #1 if1.flush = 1'b0;
    chk("flush_busy", 32'(if1.busy), 32'd0);
    @(posedge clk); #1;

    // Reset on busy cycle 10: HI/LO cleared
    issue(1, 1'b1, 1'b0, 32'd3, 32'd5, "reset_mid", 32'd0, 32'd0, 10);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("reset_busy", 32'(if1.busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q4_drained", 32'(q4.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
